// File: rtl/intersection_pkg.sv
// Shared types and light encodings for the two-road intersection controller.
package intersection_pkg;

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        ALL_RED_A,
        EW_GREEN,
        EW_YELLOW,
        ALL_RED_B
    } state_t;

    typedef logic [3:0] dur_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic state_t next_state_of(input state_t s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return ALL_RED_A;
            ALL_RED_A: return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return ALL_RED_B;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [2:0] ns_light_of(input state_t s);
        case (s)
            NS_GREEN:  return LIGHT_GREEN;
            NS_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_light_of(input state_t s);
        case (s)
            EW_GREEN:  return LIGHT_GREEN;
            EW_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    function automatic logic is_green(input state_t s);
        return (s == NS_GREEN) || (s == EW_GREEN);
    endfunction

    function automatic logic is_yellow(input state_t s);
        return (s == NS_YELLOW) || (s == EW_YELLOW);
    endfunction

    function automatic logic is_all_red(input state_t s);
        return (s == ALL_RED_A) || (s == ALL_RED_B);
    endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Down-counter holding the seconds left in the current phase; expire flags the last tick.
module phase_timer
    import intersection_pkg::*;
#(
    parameter dur_t RESET_VALUE = 4'd8
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  dur_t load_value,
    input  logic tick,
    output dur_t count,
    output logic expire
);

    assign expire = tick && (count == 4'd1);

    // NOTE: reset is synchronous, so it lives inside the clocked branch and wins over load/tick.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (tick) begin
            count <= count - 4'd1;
        end
    end

endmodule

// File: rtl/intersection_controller.sv
// Two-road traffic-light sequencer driven by a 1 Hz tick strobe.
// Define PED_REQ_EN to include pedestrian request handling (shortened green, walk phase).
module intersection_controller
    import intersection_pkg::*;
#(
    parameter dur_t GREEN_S     = 4'd8,
    parameter dur_t YELLOW_S    = 4'd3,
    parameter dur_t ALLRED_S    = 4'd1,
    parameter dur_t PED_SHORT_S = 4'd2,
    parameter dur_t PED_WALK_S  = 4'd5
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [3:0] sec_left,
    output logic       phase_done
);

    state_t state;
    state_t next_state;
    logic   expire;
    logic   load;
    dur_t   load_value;
    logic   ped_active;
    logic   serve_now;

`ifdef PED_REQ_EN
    logic ped_pending;
    logic serve;     // captured on yellow entry: the following all-red is a walk phase
    assign ped_active = ped_pending;
    assign serve_now  = serve;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_active     = 1'b0;
    assign serve_now      = 1'b0;
    assign ped_walk       = 1'b0;
`endif

    phase_timer #(.RESET_VALUE(GREEN_S)) u_timer (
        .clk        (CLOCK_50),
        .resetn     (resetn),
        .load       (load),
        .load_value (load_value),
        .tick       (tick),
        .count      (sec_left),
        .expire     (expire)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = next_state_of(state);
        load       = 1'b0;
        load_value = sec_left;
        if (expire) begin
            load = 1'b1;
            case (next_state)
                NS_GREEN, EW_GREEN:   load_value = GREEN_S;
                NS_YELLOW, EW_YELLOW: load_value = YELLOW_S;
                default:              load_value = serve_now ? PED_WALK_S : ALLRED_S;
            endcase
        end else if (tick && is_green(state) && ped_active && (sec_left > PED_SHORT_S)) begin
            load       = 1'b1;
            load_value = PED_SHORT_S;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state      <= NS_GREEN;
            ns_light   <= LIGHT_GREEN;
            ew_light   <= LIGHT_RED;
            phase_done <= 1'b0;
`ifdef PED_REQ_EN
            ped_pending <= 1'b0;
            serve       <= 1'b0;
            ped_walk    <= 1'b0;
`endif
        end else begin
            phase_done <= expire;
            if (expire) begin
                state    <= next_state;
                ns_light <= ns_light_of(next_state);
                ew_light <= ew_light_of(next_state);
            end
`ifdef PED_REQ_EN
            if (expire && is_yellow(next_state)) begin
                serve <= ped_pending;
            end
            if (expire) begin
                ped_walk <= is_all_red(next_state) && serve;
            end
            // A new request wins over the clear so it is kept for the next cycle.
            if (ped_req) begin
                ped_pending <= 1'b1;
            end else if (expire && is_all_red(next_state) && serve) begin
                ped_pending <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench for intersection_controller: a phase-table model predicts every cycle's outputs.
module tb_intersection_controller;

    localparam int GREEN_S     = 8;
    localparam int YELLOW_S    = 3;
    localparam int ALLRED_S    = 1;
    localparam int PED_SHORT_S = 2;
    localparam int PED_WALK_S  = 5;

`ifdef PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic [3:0] sec_left;
    logic       phase_done;

    intersection_controller dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .tick       (tick),
        .ped_req    (ped_req),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .ped_walk   (ped_walk),
        .sec_left   (sec_left),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic [3:0] sec;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   stim_done = 1'b0;

    // Phase table: index 0..5 = NS green, NS yellow, all-red A, EW green, EW yellow, all-red B.
    logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int m_phase, m_rem;
    bit m_pend, m_serve, m_walk, m_done;

    function automatic int phase_len(input int ph, input bit walk_phase);
        case (ph)
            0, 3:    return GREEN_S;
            1, 4:    return YELLOW_S;
            default: return walk_phase ? PED_WALK_S : ALLRED_S;
        endcase
    endfunction

    task automatic model_step(input bit rst_n, input bit tk, input bit pr);
        bit served;
        served = 1'b0;
        if (!rst_n) begin
            m_phase = 0; m_rem = GREEN_S; m_pend = 0; m_serve = 0; m_walk = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (tk) begin
            if (m_rem == 1) begin
                m_phase = (m_phase + 1) % 6;
                m_done  = 1;
                if (m_phase == 1 || m_phase == 4) m_serve = m_pend;
                m_walk  = (m_phase == 2 || m_phase == 5) && m_serve;
                served  = m_walk;
                m_rem   = phase_len(m_phase, m_walk);
            end else if ((m_phase == 0 || m_phase == 3) && m_pend && m_rem > PED_SHORT_S) begin
                m_rem = PED_SHORT_S;
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (PED_EN) m_pend = pr | (m_pend & ~served);
        else        m_pend = 0;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.ns   = ns_tab[m_phase];
        o.ew   = ew_tab[m_phase];
        o.walk = PED_EN & m_walk;
        o.sec  = 4'(m_rem);
        o.done = m_done;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got ns=%b ew=%b walk=%b sec=%0d done=%b, expected ns=%b ew=%b walk=%b sec=%0d done=%b",
                     name, got.ns, got.ew, got.walk, got.sec, got.done,
                     want.ns, want.ew, want.walk, want.sec, want.done);
        end
    endtask

    // One stimulus cycle: drive on the falling edge and queue the state expected after the next rising edge.
    task automatic cycle(input bit rst_n, input bit tk, input bit pr);
        @(negedge clk);
        resetn  = rst_n;
        tick    = tk;
        ped_req = pr;
        model_step(rst_n, tk, pr);
        exp_q.push_back(model_obs());
    endtask

    initial begin : stimulus
        int guard;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        // Full cycle with gaps and some back-to-back ticks.
        for (int i = 0; i < 24; i++) begin
            cycle(1, 1, 0);
            if (i % 3 != 0) cycle(1, 0, 0);
        end
        // Request at sec_left=7 in NS green, then watch the walk phase play out.
        cycle(1, 1, 0);
        cycle(1, 0, 1);
        for (int i = 0; i < 14; i++) cycle(1, 1, 0);
        // Request coinciding with a tick at sec_left=6 in NS green.
        guard = 0;
        while (!(m_phase == 0 && m_rem == 6) && guard < 100) begin
            cycle(1, 1, 0);
            guard++;
        end
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        // Reset with tick high during EW yellow.
        guard = 0;
        while (m_phase != 4 && guard < 100) begin
            cycle(1, 1, 0);
            guard++;
        end
        cycle(0, 1, 1);
        cycle(1, 0, 0);
        // Request held high for a full cycle.
        for (int i = 0; i < 24; i++) cycle(1, 1, 1);
        cycle(1, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0));
        end
        stim_done = 1'b1;
    end

    initial begin : monitor
        int   cycles;
        obs_t want;
        obs_t got;
        cycles = 0;
        while (!(stim_done && exp_q.size() == 0) && cycles < 20000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{ns: ns_light, ew: ew_light, walk: ped_walk, sec: sec_left, done: phase_done};
                check("outputs", got, want);
            end
        end
        if (cycles >= 20000) begin
            tests++;
            fails++;
            $display("FAIL timeout: ran %0d cycles, required completion before 20000", cycles);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
